// File: rtl/dma_xfer_sequencer.sv
// DMA transfer sequencer: request arbitration, HRQ/HLDA handshake and SI..S4 single-transfer cycle.
// Optional rotating priority is enabled by defining DMA_ROTATING_PRIO_EN (fixed lowest-index priority otherwise).
module dma_xfer_sequencer #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   localparam int CH_W  = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] dreq,
   input  logic              hlda,
   input  logic              ready,
   input  logic [NUM_CH-1:0] dir_wr,
   input  logic              load_en,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [CNT_W-1:0]  load_cnt,
   output logic              hrq,
   output logic [NUM_CH-1:0] dack,
   output logic              aen,
   output logic              adstb,
   output logic              ior_n,
   output logic              iow_n,
   output logic              memr_n,
   output logic              memw_n,
   output logic              eop_n,
   output logic [5:0]        state
);

   typedef enum logic [5:0] {
      ST_SI = 6'b000001,
      ST_SO = 6'b000010,
      ST_S1 = 6'b000100,
      ST_S2 = 6'b001000,
      ST_S3 = 6'b010000,
      ST_S4 = 6'b100000
   } state_t;

   state_t            state_reg, state_next;
   logic [CH_W-1:0]   win_reg, win_next, pick;
   logic              dir_reg, dir_next;
   logic [CNT_W-1:0]  cnt_reg [NUM_CH];
   logic [NUM_CH-1:0] eligible, dec, ld;
   logic              any_eligible, busy;

   logic              hrq_next, aen_next, adstb_next, eop_n_next;
   logic              ior_n_next, iow_n_next, memr_n_next, memw_n_next;
   logic [NUM_CH-1:0] dack_next;
   logic              busy_next, rd_low, wr_low;

   assign busy         = (state_reg != ST_SI) && (state_reg != ST_SO);
   assign any_eligible = |eligible;
   assign state        = state_reg;

   // Loads to the channel currently owning the bus are dropped so its count cannot change mid-transfer.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign eligible[gi] = dreq[gi] && (cnt_reg[gi] != '0);
         assign dec[gi]      = (state_reg == ST_S4) && (win_reg == CH_W'(gi));
         assign ld[gi]       = load_en && (load_ch == CH_W'(gi)) && !(busy && (win_reg == CH_W'(gi)));

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               cnt_reg[gi] <= '0;
            else if (dec[gi])
               cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
            else if (ld[gi])
               cnt_reg[gi] <= load_cnt;
         end
      end
   endgenerate

`ifdef DMA_ROTATING_PRIO_EN
   logic [CH_W-1:0] ptr_reg;
   logic [CH_W:0]   sum;
   logic            found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum = {1'b0, ptr_reg} + (CH_W+1)'(i);
         if (sum >= (CH_W+1)'(NUM_CH))
            sum = sum - (CH_W+1)'(NUM_CH);
         if (!found && eligible[sum[CH_W-1:0]]) begin
            pick  = sum[CH_W-1:0];
            found = 1'b1;
         end
      end
   end

   // Only completed transfers advance the pointer; aborts never reach S4.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr_reg <= '0;
      else if (state_reg == ST_S4)
         ptr_reg <= (win_reg == CH_W'(NUM_CH-1)) ? '0 : win_reg + 1'b1;
   end
`else
   always_comb begin
      pick = '0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (eligible[CH_W'(i)])
            pick = CH_W'(i);
   end
`endif

   always_comb begin
      state_next = state_reg;
      win_next   = win_reg;
      dir_next   = dir_reg;
      case (state_reg)
         ST_SI: if (any_eligible) state_next = ST_SO;
         ST_SO: begin
            if (!any_eligible)
               state_next = ST_SI;
            else if (hlda) begin
               state_next = ST_S1;
               win_next   = pick;
               dir_next   = dir_wr[pick];
            end
         end
         ST_S1: state_next = hlda ? ST_S2 : ST_SI;
         ST_S2: state_next = hlda ? ST_S3 : ST_SI;
         ST_S3: begin
            if (!hlda)
               state_next = ST_SI;
            else if (ready)
               state_next = ST_S4;
         end
         ST_S4:   state_next = ST_SI;
         default: state_next = ST_SI;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they are valid for the whole state.
   always_comb begin
      busy_next   = (state_next != ST_SI) && (state_next != ST_SO);
      rd_low      = (state_next == ST_S2) || (state_next == ST_S3);
      wr_low      = (state_next == ST_S3);
      hrq_next    = (state_next != ST_SI);
      aen_next    = busy_next;
      adstb_next  = (state_next == ST_S1);
      ior_n_next  = !(rd_low && dir_next);
      memr_n_next = !(rd_low && !dir_next);
      memw_n_next = !(wr_low && dir_next);
      iow_n_next  = !(wr_low && !dir_next);
      eop_n_next  = !((state_next == ST_S4) && (cnt_reg[win_reg] == CNT_W'(1)));
      dack_next   = '0;
      if (busy_next)
         dack_next[win_next] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_SI;
         win_reg   <= '0;
         dir_reg   <= 1'b0;
         hrq       <= 1'b0;
         dack      <= '0;
         aen       <= 1'b0;
         adstb     <= 1'b0;
         ior_n     <= 1'b1;
         iow_n     <= 1'b1;
         memr_n    <= 1'b1;
         memw_n    <= 1'b1;
         eop_n     <= 1'b1;
      end else begin
         state_reg <= state_next;
         win_reg   <= win_next;
         dir_reg   <= dir_next;
         hrq       <= hrq_next;
         dack      <= dack_next;
         aen       <= aen_next;
         adstb     <= adstb_next;
         ior_n     <= ior_n_next;
         iow_n     <= iow_n_next;
         memr_n    <= memr_n_next;
         memw_n    <= memw_n_next;
         eop_n     <= eop_n_next;
      end
   end

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Directed bench for dma_xfer_sequencer (NUM_CH=4); expectations follow DMA_ROTATING_PRIO_EN when defined.
module tb_dma_xfer_sequencer;

   localparam logic [5:0] SI = 6'b000001, SO = 6'b000010, S1 = 6'b000100,
                          S2 = 6'b001000, S3 = 6'b010000, S4 = 6'b100000;

   logic        clk, reset_n, hlda, ready, load_en;
   logic [3:0]  dreq, dir_wr, dack;
   logic [1:0]  load_ch;
   logic [15:0] load_cnt;
   logic        hrq, aen, adstb, ior_n, iow_n, memr_n, memw_n, eop_n;
   logic [5:0]  state;
   logic [17:0] obs;
   int          checks = 0;
   int          failures = 0;

   dma_xfer_sequencer #(.NUM_CH(4), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .dreq(dreq), .hlda(hlda), .ready(ready),
      .dir_wr(dir_wr), .load_en(load_en), .load_ch(load_ch), .load_cnt(load_cnt),
      .hrq(hrq), .dack(dack), .aen(aen), .adstb(adstb), .ior_n(ior_n), .iow_n(iow_n),
      .memr_n(memr_n), .memw_n(memw_n), .eop_n(eop_n), .state(state)
   );

   assign obs = {hrq, dack, aen, adstb, ior_n, iow_n, memr_n, memw_n, eop_n, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output vector for a state, written from the bus-cycle table.
   function automatic logic [17:0] exp_vec(input logic [5:0] st, input int ch, input logic dirw, input logic tc);
      logic busy, rd, wr;
      logic [3:0] dk;
      busy = (st == S1) || (st == S2) || (st == S3) || (st == S4);
      rd   = (st == S2) || (st == S3);
      wr   = (st == S3);
      dk   = busy ? (4'b0001 << ch) : 4'b0000;
      return {st != SI, dk, busy, st == S1, !(rd && dirw), !(wr && !dirw),
              !(rd && !dirw), !(wr && dirw), !tc, st};
   endfunction

   task automatic chk(input string tag, input logic [5:0] st, input int ch, input logic dirw, input logic tc);
      logic [17:0] e;
      e = exp_vec(st, ch, dirw, tc);
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] ch, input logic [15:0] cnt);
      load_en = 1'b1; load_ch = ch; load_cnt = cnt;
      tick();
      load_en = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      dreq = 4'b0000; hlda = 1'b1; ready = 1'b1; load_en = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   // One full transfer starting from SI with an eligible request.
   task automatic run_xfer(input string tag, input int ch, input logic dirw, input logic tc);
      tick(); chk({tag, "_so"}, SO, ch, dirw, 1'b0);
      tick(); chk({tag, "_s1"}, S1, ch, dirw, 1'b0);
      tick(); chk({tag, "_s2"}, S2, ch, dirw, 1'b0);
      tick(); chk({tag, "_s3"}, S3, ch, dirw, 1'b0);
      tick(); chk({tag, "_s4"}, S4, ch, dirw, tc);
      tick(); chk({tag, "_si"}, SI, ch, dirw, 1'b0);
      $display("xfer %s ch=%0d dir_wr=%0b tc=%0b", tag, ch, dirw, tc);
   endtask

   initial begin
      reset_n = 1'b1; dreq = 4'b0000; hlda = 1'b0; ready = 1'b1;
      dir_wr = 4'b0100; load_en = 1'b0; load_ch = 2'd0; load_cnt = 16'd0;
      #2 reset_n = 1'b0;
      #1 chk("reset", SI, 0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      hlda = 1'b1;

      // 1: three transfers on ch2 (IO->mem), TC on the third
      load(2'd2, 16'd3);
      chk("t1_idle", SI, 0, 1'b0, 1'b0);
      dreq = 4'b0100;
      run_xfer("t1_a", 2, 1'b1, 1'b0);
      run_xfer("t1_b", 2, 1'b1, 1'b0);
      run_xfer("t1_c", 2, 1'b1, 1'b1);
      tick(); chk("t1_done", SI, 0, 1'b0, 1'b0);
      dreq = 4'b0000;

      // 2: ch0 and ch3 both requesting, two words each, mem->IO
      do_reset();
      dir_wr = 4'b0000;
      load(2'd0, 16'd2);
      load(2'd3, 16'd2);
      dreq = 4'b1001;
`ifdef DMA_ROTATING_PRIO_EN
      run_xfer("t2_a", 0, 1'b0, 1'b0);
      run_xfer("t2_b", 3, 1'b0, 1'b0);
      run_xfer("t2_c", 0, 1'b0, 1'b1);
      run_xfer("t2_d", 3, 1'b0, 1'b1);
`else
      run_xfer("t2_a", 0, 1'b0, 1'b0);
      run_xfer("t2_b", 0, 1'b0, 1'b1);
      run_xfer("t2_c", 3, 1'b0, 1'b0);
      run_xfer("t2_d", 3, 1'b0, 1'b1);
`endif
      tick(); chk("t2_done", SI, 0, 1'b0, 1'b0);
      dreq = 4'b0000;

      // 3: READY low for four edges stretches S3 to five cycles
      do_reset();
      load(2'd1, 16'd2);
      dreq = 4'b0010;
      tick(); chk("t3_so", SO, 1, 1'b0, 1'b0);
      tick(); chk("t3_s1", S1, 1, 1'b0, 1'b0);
      tick(); chk("t3_s2", S2, 1, 1'b0, 1'b0);
      tick(); chk("t3_s3_0", S3, 1, 1'b0, 1'b0);
      ready = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick(); chk($sformatf("t3_s3_%0d", i), S3, 1, 1'b0, 1'b0);
      end
      ready = 1'b1;
      tick(); chk("t3_s4", S4, 1, 1'b0, 1'b0);
      tick(); chk("t3_si", SI, 1, 1'b0, 1'b0);
      $display("xfer t3 ch=1 wait_states=4");
      run_xfer("t3_b", 1, 1'b0, 1'b1);
      dreq = 4'b0000;

      // 4: SO waits for HLDA, then HLDA drops in S2 and the transfer aborts
      do_reset();
      hlda = 1'b0;
      load(2'd0, 16'd2);
      dreq = 4'b0001;
      tick(); chk("t4_so", SO, 0, 1'b0, 1'b0);
      tick(); chk("t4_so_wait", SO, 0, 1'b0, 1'b0);
      hlda = 1'b1;
      tick(); chk("t4_s1", S1, 0, 1'b0, 1'b0);
      tick(); chk("t4_s2", S2, 0, 1'b0, 1'b0);
      hlda = 1'b0;
      tick(); chk("t4_abort", SI, 0, 1'b0, 1'b0);
      $display("xfer t4 ch=0 aborted");
      hlda = 1'b1;
      run_xfer("t4_a", 0, 1'b0, 1'b0);
      run_xfer("t4_b", 0, 1'b0, 1'b1);
      dreq = 4'b0000;

      // 5: load to active ch0 in S3 dropped; load to ch1 during ch0 S4 applies
      do_reset();
      load(2'd0, 16'd2);
      dreq = 4'b0001;
      tick(); chk("t5_so", SO, 0, 1'b0, 1'b0);
      tick(); chk("t5_s1", S1, 0, 1'b0, 1'b0);
      tick(); chk("t5_s2", S2, 0, 1'b0, 1'b0);
      tick(); chk("t5_s3", S3, 0, 1'b0, 1'b0);
      load_en = 1'b1; load_ch = 2'd0; load_cnt = 16'd5;
      tick(); chk("t5_s4", S4, 0, 1'b0, 1'b0);
      load_ch = 2'd1; load_cnt = 16'd1;
      tick(); chk("t5_si", SI, 0, 1'b0, 1'b0);
      load_en = 1'b0;
      $display("xfer t5 ch=0 with concurrent loads");
      run_xfer("t5_b", 0, 1'b0, 1'b1);
      dreq = 4'b0010;
      run_xfer("t5_c", 1, 1'b0, 1'b1);
      dreq = 4'b0000;

      // 6: asynchronous reset in S3 clears outputs and counters
      do_reset();
      dir_wr = 4'b1000;
      load(2'd3, 16'd2);
      dreq = 4'b1000;
      tick(); chk("t6_so", SO, 3, 1'b1, 1'b0);
      tick(); chk("t6_s1", S1, 3, 1'b1, 1'b0);
      tick(); chk("t6_s2", S2, 3, 1'b1, 1'b0);
      tick(); chk("t6_s3", S3, 3, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk("t6_async_reset", SI, 0, 1'b0, 1'b0);
      tick();
      reset_n = 1'b1;
      tick(); chk("t6_cnt_zero_a", SI, 0, 1'b0, 1'b0);
      tick(); chk("t6_cnt_zero_b", SI, 0, 1'b0, 1'b0);
      $display("xfer t6 ch=3 reset mid-transfer");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
